// File: rtl/game_flow_fsm_pkg.sv
// Shared types and constants for the game flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [1:0] COUNTDOWN_START = 2'd3;

  // Multiplayer result: the player who did not lose wins; both losing is a draw.
  function automatic logic [1:0] multi_winner(input logic [1:0] lost);
    logic [1:0] w;
    w = WIN_NONE;
    case (lost)
      2'b01:   w = WIN_P2;
      2'b10:   w = WIN_P1;
      2'b11:   w = WIN_DRAW;
      default: w = WIN_NONE;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/game_flow_fsm_tick_gen.sv
// Countdown prescaler: one-cycle tick every TICK_DIV enabled cycles, synchronous clear.
module tick_gen #(
  parameter int unsigned TICK_DIV = 65_000_000
) (
  input  logic clk65MHz,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk65MHz) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/game_flow_fsm.sv
// Game flow controller: IDLE -> COUNTDOWN -> PLAY (<-> PAUSE) -> GAME_OVER.
// Optional pause support is compiled in with GAME_FLOW_PAUSE_EN.
module game_flow_fsm
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV = 65_000_000
) (
  input  logic       clk65MHz,
  input  logic       rst,
  input  logic       screen_idle,
  input  logic       screen_single,
  input  logic       screen_multi,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [1:0] player_lost,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic       game_active,
  output logic       game_paused,
  output logic       mode_multi,
  output logic [1:0] winner,
  output logic       game_start
);

  game_state_t st;
  logic        start_prev;
  logic        start_edge;
  logic        go_start;
  logic        abort;
  logic        tick;
  logic        loss;
  logic [1:0]  loss_winner;

  assign start_edge = btn_start & ~start_prev;
  assign go_start   = start_edge & ~screen_idle & (screen_single | screen_multi);
  assign abort      = (st != IDLE) && (screen_idle || (screen_multi != mode_multi));

  always_comb begin
    loss        = 1'b0;
    loss_winner = WIN_NONE;
    if (mode_multi) begin
      loss        = |player_lost;
      loss_winner = multi_winner(player_lost);
    end else begin
      loss        = player_lost[0];
    end
  end

  // Prescaler is held cleared outside COUNTDOWN so every entry starts a full second.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk65MHz (clk65MHz),
    .rst      (rst),
    .clr      ((st != COUNTDOWN) || abort),
    .en       (st == COUNTDOWN),
    .tick     (tick)
  );

`ifdef GAME_FLOW_PAUSE_EN
  logic pause_prev;
  logic pause_edge;
  logic paused_q;

  assign pause_edge  = btn_pause & ~pause_prev;
  assign game_paused = paused_q;
`else
  logic btn_pause_unused;

  assign btn_pause_unused = btn_pause;
  assign game_paused      = 1'b0;
`endif

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      st          <= IDLE;
      countdown   <= '0;
      game_active <= 1'b0;
      mode_multi  <= 1'b0;
      winner      <= WIN_NONE;
      game_start  <= 1'b0;
      start_prev  <= 1'b1;
`ifdef GAME_FLOW_PAUSE_EN
      pause_prev  <= 1'b1;
      paused_q    <= 1'b0;
`endif
    end else begin
      start_prev <= btn_start;
      game_start <= 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
      pause_prev <= btn_pause;
`endif
      if (abort) begin
        st          <= IDLE;
        countdown   <= '0;
        winner      <= WIN_NONE;
        game_active <= 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
        paused_q    <= 1'b0;
`endif
      end else begin
        case (st)
          IDLE: begin
            if (go_start) begin
              st         <= COUNTDOWN;
              mode_multi <= screen_multi;
              countdown  <= COUNTDOWN_START;
              winner     <= WIN_NONE;
            end
          end
          COUNTDOWN: begin
            if (tick) begin
              if (countdown == 2'd1) begin
                st          <= PLAY;
                countdown   <= '0;
                game_start  <= 1'b1;
                game_active <= 1'b1;
              end else begin
                countdown <= countdown - 2'd1;
              end
            end
          end
          PLAY: begin
            if (loss) begin
              st          <= GAME_OVER;
              winner      <= loss_winner;
              game_active <= 1'b0;
            end
`ifdef GAME_FLOW_PAUSE_EN
            else if (pause_edge) begin
              st          <= PAUSE;
              game_active <= 1'b0;
              paused_q    <= 1'b1;
            end
`endif
          end
`ifdef GAME_FLOW_PAUSE_EN
          PAUSE: begin
            if (pause_edge) begin
              st          <= PLAY;
              game_active <= 1'b1;
              paused_q    <= 1'b0;
            end
          end
`endif
          GAME_OVER: begin
            if (start_edge) begin
              st        <= COUNTDOWN;
              countdown <= COUNTDOWN_START;
              winner    <= WIN_NONE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed bench for game_flow_fsm with TICK_DIV=4.
module tb_game_flow_fsm;
  import game_pkg::*;

  logic       clk65MHz = 1'b0;
  logic       rst = 1'b1;
  logic       screen_idle = 1'b0;
  logic       screen_single = 1'b0;
  logic       screen_multi = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [1:0] player_lost = 2'b00;
  logic [2:0] state;
  logic [1:0] countdown;
  logic       game_active;
  logic       game_paused;
  logic       mode_multi;
  logic [1:0] winner;
  logic       game_start;

  int tests = 0;
  int fails = 0;
  logic [10:0] obs;
  logic [10:0] exp;

  game_flow_fsm #(
    .TICK_DIV (4)
  ) dut (
    .clk65MHz      (clk65MHz),
    .rst           (rst),
    .screen_idle   (screen_idle),
    .screen_single (screen_single),
    .screen_multi  (screen_multi),
    .btn_start     (btn_start),
    .btn_pause     (btn_pause),
    .player_lost   (player_lost),
    .state         (state),
    .countdown     (countdown),
    .game_active   (game_active),
    .game_paused   (game_paused),
    .mode_multi    (mode_multi),
    .winner        (winner),
    .game_start    (game_start)
  );

  always #5 clk65MHz = ~clk65MHz;

  assign obs = {state, countdown, game_active, game_paused, mode_multi, winner, game_start};

  function automatic logic [10:0] pack(game_state_t s, logic [1:0] cd, logic act, logic pau,
                                       logic mm, logic [1:0] win, logic gs);
    return {s, cd, act, pau, mm, win, gs};
  endfunction

  task automatic press_start();
    btn_start = 1'b1;
    @(negedge clk65MHz);
    btn_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk65MHz);
    exp = pack(IDLE, 2'd0, 1'b0, 1'b0, 1'b0, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL reset: got %h want %h", obs, exp); end
    rst = 1'b0;
    @(negedge clk65MHz);
  endtask

  task automatic test_idle_ignore();
    screen_idle = 1'b1;
    press_start();
    @(negedge clk65MHz);
    exp = pack(IDLE, 2'd0, 1'b0, 1'b0, 1'b0, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL idle_ignore: got %h want %h", obs, exp); end
  endtask

  task automatic test_countdown();
    screen_idle   = 1'b0;
    screen_single = 1'b1;
    @(negedge clk65MHz);
    press_start();
    for (int c = 3; c >= 1; c--) begin
      for (int k = 0; k < 4; k++) begin
        if (!(c == 3 && k == 0)) @(negedge clk65MHz);
        exp = pack(COUNTDOWN, 2'(c), 1'b0, 1'b0, 1'b0, WIN_NONE, 1'b0);
        tests++;
        if (obs !== exp) begin
          fails++; $display("FAIL cd_seq c=%0d k=%0d: got %h want %h", c, k, obs, exp);
        end
      end
    end
    @(negedge clk65MHz);
    exp = pack(PLAY, 2'd0, 1'b1, 1'b0, 1'b0, WIN_NONE, 1'b1);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL cd_play: got %h want %h", obs, exp); end
    @(negedge clk65MHz);
    exp = pack(PLAY, 2'd0, 1'b1, 1'b0, 1'b0, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL start_pulse_len: got %h want %h", obs, exp); end
  endtask

  task automatic test_single_loss();
    player_lost = 2'b10;
    @(negedge clk65MHz);
    player_lost = 2'b00;
    exp = pack(PLAY, 2'd0, 1'b1, 1'b0, 1'b0, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL single_p2_ignored: got %h want %h", obs, exp); end
    player_lost = 2'b01;
    @(negedge clk65MHz);
    player_lost = 2'b00;
    exp = pack(GAME_OVER, 2'd0, 1'b0, 1'b0, 1'b0, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL single_loss: got %h want %h", obs, exp); end
  endtask

  task automatic test_multi_draw();
    screen_single = 1'b0;
    screen_idle   = 1'b1;
    @(negedge clk65MHz);
    exp = pack(IDLE, 2'd0, 1'b0, 1'b0, 1'b0, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL over_abort: got %h want %h", obs, exp); end
    screen_idle  = 1'b0;
    screen_multi = 1'b1;
    press_start();
    exp = pack(COUNTDOWN, 2'd3, 1'b0, 1'b0, 1'b1, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL multi_enter: got %h want %h", obs, exp); end
    repeat (12) @(negedge clk65MHz);
    exp = pack(PLAY, 2'd0, 1'b1, 1'b0, 1'b1, WIN_NONE, 1'b1);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL multi_play: got %h want %h", obs, exp); end
    player_lost = 2'b11;
    @(negedge clk65MHz);
    player_lost = 2'b00;
    exp = pack(GAME_OVER, 2'd0, 1'b0, 1'b0, 1'b1, WIN_DRAW, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL multi_draw: got %h want %h", obs, exp); end
    press_start();
    exp = pack(COUNTDOWN, 2'd3, 1'b0, 1'b0, 1'b1, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL restart: got %h want %h", obs, exp); end
  endtask

  task automatic test_pause();
    repeat (12) @(negedge clk65MHz);
    exp = pack(PLAY, 2'd0, 1'b1, 1'b0, 1'b1, WIN_NONE, 1'b1);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL restart_play: got %h want %h", obs, exp); end
    @(negedge clk65MHz);
`ifdef GAME_FLOW_PAUSE_EN
    btn_pause = 1'b1;
    @(negedge clk65MHz);
    btn_pause = 1'b0;
    exp = pack(PAUSE, 2'd0, 1'b0, 1'b1, 1'b1, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL pause_enter: got %h want %h", obs, exp); end
    player_lost = 2'b01;
    @(negedge clk65MHz);
    player_lost = 2'b00;
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL pause_loss_ignored: got %h want %h", obs, exp); end
    btn_pause = 1'b1;
    @(negedge clk65MHz);
    btn_pause = 1'b0;
    exp = pack(PLAY, 2'd0, 1'b1, 1'b0, 1'b1, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL pause_exit: got %h want %h", obs, exp); end
`else
    btn_pause = 1'b1;
    @(negedge clk65MHz);
    btn_pause = 1'b0;
    exp = pack(PLAY, 2'd0, 1'b1, 1'b0, 1'b1, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL pause_disabled: got %h want %h", obs, exp); end
`endif
  endtask

  task automatic test_loss_priority();
    player_lost = 2'b10;
    btn_pause   = 1'b1;
    @(negedge clk65MHz);
    player_lost = 2'b00;
    btn_pause   = 1'b0;
    exp = pack(GAME_OVER, 2'd0, 1'b0, 1'b0, 1'b1, WIN_P1, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL loss_over_pause: got %h want %h", obs, exp); end
    press_start();
    repeat (12) @(negedge clk65MHz);
    player_lost = 2'b01;
    @(negedge clk65MHz);
    player_lost = 2'b00;
    exp = pack(GAME_OVER, 2'd0, 1'b0, 1'b0, 1'b1, WIN_P2, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL p2_wins: got %h want %h", obs, exp); end
    press_start();
    repeat (12) @(negedge clk65MHz);
    player_lost  = 2'b01;
    screen_multi = 1'b0;
    screen_idle  = 1'b1;
    @(negedge clk65MHz);
    player_lost = 2'b00;
    tests++;
    if ({state, countdown, winner, game_active} !== {IDLE, 2'd0, WIN_NONE, 1'b0}) begin
      fails++;
      $display("FAIL abort_over_loss: got %h want %h", {state, countdown, winner, game_active},
               {IDLE, 2'd0, WIN_NONE, 1'b0});
    end
  endtask

  task automatic test_abort_countdown();
    screen_idle   = 1'b0;
    screen_single = 1'b1;
    press_start();
    exp = pack(COUNTDOWN, 2'd3, 1'b0, 1'b0, 1'b0, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL abort_setup: got %h want %h", obs, exp); end
    repeat (5) @(negedge clk65MHz);
    exp = pack(COUNTDOWN, 2'd2, 1'b0, 1'b0, 1'b0, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL abort_mid: got %h want %h", obs, exp); end
    screen_single = 1'b0;
    screen_multi  = 1'b1;
    @(negedge clk65MHz);
    tests++;
    if ({state, countdown, winner} !== {IDLE, 2'd0, WIN_NONE}) begin
      fails++;
      $display("FAIL mode_abort: got %h want %h", {state, countdown, winner}, {IDLE, 2'd0, WIN_NONE});
    end
    press_start();
    repeat (3) @(negedge clk65MHz);
    exp = pack(COUNTDOWN, 2'd3, 1'b0, 1'b0, 1'b1, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL prescaler_clear: got %h want %h", obs, exp); end
    @(negedge clk65MHz);
    exp = pack(COUNTDOWN, 2'd2, 1'b0, 1'b0, 1'b1, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL prescaler_tick: got %h want %h", obs, exp); end
  endtask

  task automatic test_reset_mid();
    rst           = 1'b1;
    btn_start     = 1'b1;
    screen_multi  = 1'b0;
    screen_single = 1'b1;
    @(negedge clk65MHz);
    exp = pack(IDLE, 2'd0, 1'b0, 1'b0, 1'b0, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL reset_mid: got %h want %h", obs, exp); end
    repeat (2) @(negedge clk65MHz);
    rst = 1'b0;
    repeat (3) @(negedge clk65MHz);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL held_start: got %h want %h", obs, exp); end
    btn_start = 1'b0;
    @(negedge clk65MHz);
    press_start();
    exp = pack(COUNTDOWN, 2'd3, 1'b0, 1'b0, 1'b0, WIN_NONE, 1'b0);
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL repress_start: got %h want %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_countdown();
    test_single_loss();
    test_multi_draw();
    test_pause();
    test_loss_priority();
    test_abort_countdown();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
